// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared LIF types, current format defaults, saturation helper and synapse FSM states
package lif_pkg;

  localparam int LIF_I_WIDTH      = 8;
  localparam int LIF_I_FRAC_WIDTH = 4;

  typedef logic signed [LIF_I_WIDTH-1:0] current_t;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN0,
    DRAIN1,
    DECAY
  } syn_state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/lif_weight_ram.sv
// rtl/lif_weight_ram.sv - per-synapse weight table, one write port, registered read-before-write read port
module lif_weight_ram #(
  parameter int NUM_SYN    = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_SYN];

  // Out-of-range reads return a zero weight so such events contribute nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYN; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && (int'(wr_addr) < NUM_SYN)) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= (int'(rd_addr) < NUM_SYN) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/lif_synapse_integrator.sv
// rtl/lif_synapse_integrator.sv - weighted spike accumulator with per-tick leak and saturated current output
// Optional event statistics port ev_count enabled by defining LIF_SYN_STATS_EN.
module lif_synapse_integrator
  import lif_pkg::*;
#(
  parameter int NUM_SYN      = 16,
  parameter int SYN_ID_WIDTH = $clog2(NUM_SYN),
  parameter int W_WIDTH      = 8,
  parameter int I_WIDTH      = LIF_I_WIDTH,
  parameter int I_FRAC_WIDTH = LIF_I_FRAC_WIDTH,
  parameter int ACC_WIDTH    = 12,
  parameter int TAU_SHIFT    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [SYN_ID_WIDTH-1:0] wr_addr,
  input  logic [W_WIDTH-1:0]      wr_data,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic [SYN_ID_WIDTH-1:0] ev_syn_id,
  input  logic                    tick,
  output logic [I_WIDTH-1:0]      current_out,
  output logic                    current_valid,
  output logic                    tick_overrun
`ifdef LIF_SYN_STATS_EN
  ,
  output logic [15:0]             ev_count
`endif
);

  if (ACC_WIDTH < W_WIDTH || ACC_WIDTH < I_WIDTH || I_FRAC_WIDTH >= I_WIDTH) begin : g_bad_cfg
    $error("lif_synapse_integrator: inconsistent width parameters");
  end

  syn_state_e                  state;
  logic                        accept;
  logic                        s1_valid;
  logic [W_WIDTH-1:0]          w_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [31:0]          acc_sum;

  assign ev_ready = (state == ACCUM);
  assign accept   = ev_valid && ev_ready;
  assign acc_sum  = 32'(acc) + 32'($signed(w_q));

  lif_weight_ram #(
    .NUM_SYN   (NUM_SYN),
    .ADDR_WIDTH(SYN_ID_WIDTH),
    .DATA_WIDTH(W_WIDTH)
  ) u_weight_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (accept),
    .rd_addr(ev_syn_id),
    .rd_data(w_q)
  );

  // Events cannot be accepted after the tick cycle, so stage 2 is always idle during DECAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      s1_valid      <= 1'b0;
      acc           <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      s1_valid      <= accept;
      current_valid <= (state == DECAY);
      if (tick && state != ACCUM) tick_overrun <= 1'b1;

      case (state)
        ACCUM:   if (tick) state <= DRAIN0;
        DRAIN0:  state <= DRAIN1;
        DRAIN1:  state <= DECAY;
        DECAY:   state <= ACCUM;
        default: state <= ACCUM;
      endcase

      if (state == DECAY) begin
        current_out <= I_WIDTH'(sat_to_width(32'(acc), I_WIDTH));
        acc         <= acc - (acc >>> TAU_SHIFT);
      end else if (s1_valid) begin
        acc <= ACC_WIDTH'(sat_to_width(acc_sum, ACC_WIDTH));
      end
    end
  end

`ifdef LIF_SYN_STATS_EN
  logic [15:0] ev_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_cnt   <= '0;
      ev_count <= '0;
    end else if (state == DECAY) begin
      ev_count <= ev_cnt;
      ev_cnt   <= '0;
    end else if (accept && ev_cnt != 16'hFFFF) begin
      ev_cnt <= ev_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/lif_synapse_integrator.md
# lif_synapse_integrator

Upstream feeder for the fixed-parameter LIF neuron. It accepts pre-synaptic spike events over a valid/ready handshake and looks up a per-synapse signed weight. Weighted events accumulate into a leaky synaptic current. On each timestep tick, the accumulated current is published as a held, saturated `I_WIDTH` Qm.`I_FRAC_WIDTH` value, ready to drive the neuron's `input_current`.

## Interface
Parameters:
- `NUM_SYN`, 16, number of synapses; weight table depth.
- `SYN_ID_WIDTH`, `$clog2(NUM_SYN)`, width of the synapse index.
- `W_WIDTH`, 8, signed weight width; `I_FRAC_WIDTH` fractional bits.
- `I_WIDTH`, 8, output current width; matches the neuron input.
- `I_FRAC_WIDTH`, 4, fractional bits shared by weights, accumulator and output.
- `ACC_WIDTH`, 12, signed accumulator width; must be ≥ `W_WIDTH` and ≥ `I_WIDTH`.
- `TAU_SHIFT`, 3, leak shift applied per timestep.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, synchronous, active-high reset.
- `wr_en`, in, 1, weight write strobe.
- `wr_addr`, in, `SYN_ID_WIDTH`, weight write index.
- `wr_data`, in, `W_WIDTH`, signed weight.
- `ev_valid`, in, 1, spike event present.
- `ev_ready`, out, 1, block can accept an event.
- `ev_syn_id`, in, `SYN_ID_WIDTH`, source synapse of the event.
- `tick`, in, 1, timestep boundary pulse.
- `current_out`, out, `I_WIDTH`, signed current, held between updates.
- `current_valid`, out, 1, one-cycle pulse when `current_out` updates.
- `tick_overrun`, out, 1, sticky flag: a tick arrived while not in ACCUM.

## Operation
- **Reset:** all weights = 0; acc = 0; `current_out` = 0; `current_valid` = 0; `tick_overrun` = 0; state = ACCUM; both pipeline stages invalid; `ev_ready` = 1 in the first cycle after reset.
- **FSM states:** ACCUM, DRAIN0, DRAIN1, DECAY.
  - ACCUM → DRAIN0 on `tick`.
  - DRAIN0 → DRAIN1 → DECAY, unconditionally.
  - DECAY → ACCUM, unconditionally.
- **Handshake:**
  - `ev_ready` = (state == ACCUM). It is a registered-state decode and does not depend on `ev_valid`.
  - An event is accepted when `ev_valid && ev_ready`.
  - `ev_syn_id` ≥ `NUM_SYN` is accepted and contributes 0.
- **Pipeline stage 1:** registered weight read `w_q = weight[ev_syn_id]`. A same-cycle write to the same index is read-before-write: the event uses the old weight.
- **Pipeline stage 2:** acc ← sat_ACC(acc + sign-extended `w_q`). Saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- **DECAY cycle:**
  - `current_out` ← sat_I(acc). Saturates to [−2^(I_WIDTH−1), 2^(I_WIDTH−1)−1].
  - acc ← acc − (acc >>> `TAU_SHIFT`), arithmetic (floor) shift.
  - Examples: 64 → 56; −80 → −70; −1 → 0.
  - `current_valid` is asserted the following cycle.
- **Ticks outside ACCUM** are ignored and set `tick_overrun`, which clears only on `rst`.
- **Weight writes** are accepted in every state.

## Timing
- Tick sampled at cycle T (state ACCUM).
  - An event accepted in cycle T is included in the published value.
  - T+1, T+2: DRAIN, `ev_ready` = 0.
  - T+3: DECAY.
  - T+4: `current_valid` = 1, new `current_out` visible, `ev_ready` = 1.
- Tick-to-output latency: 4 cycles. Minimum tick spacing: 4 cycles.
- Event-to-acc latency: 2 cycles. Throughput: one event per cycle in ACCUM.
- `rst` mid-operation: next cycle returns to reset state. In-flight events are discarded and weights are cleared.

## Configuration
- Macro `LIF_SYN_STATS_EN`.
- **Defined:** adds output `ev_count` [15:0].
  - Counts events accepted during the current timestep, saturating at 0xFFFF.
  - Latched into a holding register and the counter cleared in the DECAY cycle.
  - Holding register resets to 0.
- **Undefined:** the port and counters are absent; all other behaviour is identical.

## Structure
- Shared package `lif_pkg`:
  - `I_WIDTH`/`I_FRAC_WIDTH` defaults.
  - `current_t` typedef.
  - Saturate-to-width function used by both this block and the neuron.
  - FSM state enum `syn_state_e`.
- One sub-module: `lif_weight_ram`, `NUM_SYN` × `W_WIDTH`, 1 write port and 1 registered read port, read-before-write, synchronous clear on `rst`.

## Test plan
- **Accumulate and leak:** weights[3] = 24, [5] = 16; events 3, 3, 5; then tick → `current_out` = 64 with `current_valid` at T+4, acc = 56. Second tick with no events → `current_out` = 56.
- **Positive saturation:** weight[0] = 127; 20 events then tick → acc = 2047, `current_out` = 127.
- **Negative saturation:** weight[0] = −128; 20 events then tick → acc = −2048, `current_out` = −128.
- **Event on tick cycle:** an event presented in cycle T is included in the output. `ev_valid` held high during T+1..T+3 → `ev_ready` = 0, no accept; the event is accepted at T+4.
- **Tick overrun and read-before-write:** tick at T+2 → ignored, `tick_overrun` = 1. A write to weight[7] and an event on 7 in the same cycle → the event uses the old weight.
- **Reset mid-pipeline:** `rst` while events are in flight → acc = 0 and `current_out` = 0. A tick after reset → `current_out` = 0.
